// File: rtl/snn_aer_pkg.sv
// ---------------------------------------------------------------------------
// snn_aer_pkg
//   Shared types and constants for the AER transmit path between the pixel
//   encoder and the SNN core.
//   - aer_tx_state_t : handshake FSM state (4-bit encoding)
//   - AER_ADDR_W     : AER address width
//   - AER_RST_CODE   : reset-sequence address, also emitted by the encoder
// ---------------------------------------------------------------------------
package snn_aer_pkg;

    localparam int AER_ADDR_W = 10;

    localparam logic [AER_ADDR_W-1:0] AER_RST_CODE = 10'h1FF;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_ARMED  = 4'd1,
        ST_SETUP  = 4'd2,
        ST_REQ_HI = 4'd3,
        ST_REQ_LO = 4'd4
    } aer_tx_state_t;

endpackage

// File: rtl/aer_sync.sv
// ---------------------------------------------------------------------------
// aer_sync
//   Multi-flop synchroniser for a single asynchronous level (AER ACK).
//   Ports:
//     i_clk   : destination clock
//     i_rst_n : synchronous active-low reset, clears every stage
//     i_d     : asynchronous input level
//     o_q     : synchronised level, SYNC_STAGES edges behind i_d
// ---------------------------------------------------------------------------
module aer_sync #(
    parameter int SYNC_STAGES = 2   // >= 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/aer_tx_ctrl.sv
// ---------------------------------------------------------------------------
// aer_tx_ctrl
//   Takes the index the pixel encoder presents with FOUND_NEXT_INDEX and
//   sends it to the SNN core over a 4-phase REQ/ACK AER bus. Supervises each
//   handshake phase with a timeout and counts completed events.
//   Ports:
//     CLK, RST_N        : clock, synchronous active-low reset
//     NEXT_INDEX        : address from the encoder
//     FOUND_NEXT_INDEX  : encoder strobe (index valid on its last high cycle)
//     BUSY              : high in every state but IDLE (encoder back-pressure)
//     AERIN_ADDR        : AER address bus
//     AERIN_REQ         : AER request
//     AERIN_ACK         : AER acknowledge, asynchronous to CLK
//     CLR_ERR           : clears TIMEOUT_ERR
//     TIMEOUT_ERR       : sticky handshake-phase timeout flag
//     EVENT_CNT         : completed handshakes, saturating
// ---------------------------------------------------------------------------
module aer_tx_ctrl
    import snn_aer_pkg::*;
#(
    parameter int ADDR_W         = AER_ADDR_W,
    parameter int SETUP_CYCLES   = 2,     // >= 1
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int SYNC_STAGES    = 2,     // >= 2
    parameter int CNT_W          = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] NEXT_INDEX,
    input  logic              FOUND_NEXT_INDEX,
    output logic              BUSY,
    output logic [ADDR_W-1:0] AERIN_ADDR,
    output logic              AERIN_REQ,
    input  logic              AERIN_ACK,
    input  logic              CLR_ERR,
    output logic              TIMEOUT_ERR,
    output logic [CNT_W-1:0]  EVENT_CNT
);

    // One counter serves both the setup delay and the phase timeout, so it
    // must be wide enough for whichever limit is larger.
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SU_W = $clog2(SETUP_CYCLES + 1);
    localparam int PH_W = (TO_W > SU_W) ? TO_W : SU_W;

    aer_tx_state_t     r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_req;
    logic [PH_W-1:0]   r_ph_cnt;
    logic              r_err;
    logic [CNT_W-1:0]  r_evt_cnt;

    logic w_ack_s;
    logic w_setup_done;
    logic w_timeout;

    aer_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .i_clk  (CLK),
        .i_rst_n(RST_N),
        .i_d    (AERIN_ACK),
        .o_q    (w_ack_s)
    );

    // Counter is cleared on phase entry, so value k marks the (k+1)-th cycle.
    assign w_setup_done = (r_ph_cnt == PH_W'(SETUP_CYCLES - 1));
    assign w_timeout    = (r_ph_cnt == PH_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_req     <= 1'b0;
            r_ph_cnt  <= '0;
            r_err     <= 1'b0;
            r_evt_cnt <= '0;
        end else begin
            // Clear first so a timeout set later in this block wins.
            if (CLR_ERR) r_err <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (FOUND_NEXT_INDEX) begin
                        r_addr  <= NEXT_INDEX;
                        r_state <= ST_ARMED;
                    end
                end

                // Encoder index is only valid on the final strobe cycle, so
                // keep reloading until the strobe drops.
                ST_ARMED: begin
                    if (FOUND_NEXT_INDEX) begin
                        r_addr <= NEXT_INDEX;
                    end else begin
                        r_ph_cnt <= '0;
                        r_state  <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    if (w_setup_done) begin
                        r_ph_cnt <= '0;
                        r_req    <= 1'b1;
                        r_state  <= ST_REQ_HI;
                    end else begin
                        r_ph_cnt <= r_ph_cnt + PH_W'(1);
                    end
                end

                ST_REQ_HI: begin
                    if (w_ack_s) begin
                        r_ph_cnt <= '0;
                        r_req    <= 1'b0;
                        r_state  <= ST_REQ_LO;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_req   <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_ph_cnt <= r_ph_cnt + PH_W'(1);
                    end
                end

                ST_REQ_LO: begin
                    if (!w_ack_s) begin
                        if (r_evt_cnt != '1) r_evt_cnt <= r_evt_cnt + CNT_W'(1);
                        r_state <= ST_IDLE;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_ph_cnt <= r_ph_cnt + PH_W'(1);
                    end
                end

                default: begin
                    r_req   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign BUSY        = (r_state != ST_IDLE);
    assign AERIN_ADDR  = r_addr;
    assign AERIN_REQ   = r_req;
    assign TIMEOUT_ERR = r_err;
    assign EVENT_CNT   = r_evt_cnt;

endmodule

// File: tb/tb_aer_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aer_tx_ctrl
//   Scoreboarded bench. Stimulus pushes one expected record per event; a
//   negedge monitor pops it when REQ rises and closes it when BUSY falls.
//   DUT A uses TIMEOUT_CYCLES=8; DUT B shares every input and has CNT_W=4
//   so its counter saturates.
// ---------------------------------------------------------------------------
module tb_aer_tx_ctrl;

    localparam int SETUP = 2;
    localparam int TMO   = 8;

    typedef struct {
        logic [9:0] addr;
        int         req_cyc;
        int         req_len;   // 0: not checked
        int         cnt;
        int         cnt_b;
        logic       err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  idx;
    logic        strobe;
    logic        ack;
    logic        clr;

    logic        a_busy, a_req, a_err;
    logic [9:0]  a_addr;
    logic [15:0] a_cnt;
    logic        b_busy, b_req, b_err;
    logic [9:0]  b_addr;
    logic [3:0]  b_cnt;

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   ack_mode = 0;   // 0 none, 1 respond, 2 stuck high
    int   exp_cnt = 0;
    int   exp_cnt_b = 0;
    exp_t q[$];
    exp_t cur;
    bit   cur_v = 0;
    int   req_len = 0;
    logic prev_req = 1'b0;
    logic prev_busy = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aer_tx_ctrl #(.TIMEOUT_CYCLES(TMO)) u_dut_a (
        .CLK(clk), .RST_N(rst_n), .NEXT_INDEX(idx), .FOUND_NEXT_INDEX(strobe),
        .BUSY(a_busy), .AERIN_ADDR(a_addr), .AERIN_REQ(a_req), .AERIN_ACK(ack),
        .CLR_ERR(clr), .TIMEOUT_ERR(a_err), .EVENT_CNT(a_cnt)
    );

    aer_tx_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(4)) u_dut_b (
        .CLK(clk), .RST_N(rst_n), .NEXT_INDEX(idx), .FOUND_NEXT_INDEX(strobe),
        .BUSY(b_busy), .AERIN_ADDR(b_addr), .AERIN_REQ(b_req), .AERIN_ACK(ack),
        .CLR_ERR(clr), .TIMEOUT_ERR(b_err), .EVENT_CNT(b_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // ACK model: follows REQ after 3 cycles in each direction.
    initial begin
        int dly;
        dly = 0;
        ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (ack_mode == 1) begin
                if (a_req && !ack) begin
                    dly++;
                    if (dly == 3) begin ack = 1'b1; dly = 0; end
                end else if (!a_req && ack) begin
                    dly++;
                    if (dly == 3) begin ack = 1'b0; dly = 0; end
                end else begin
                    dly = 0;
                end
            end else begin
                dly = 0;
                ack = (ack_mode == 2);
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (a_req && !prev_req) begin
            if (q.size() == 0) begin
                chk("req_unexpected", 32'(1), 32'(0));
            end else begin
                cur   = q.pop_front();
                cur_v = 1;
                chk("req_latency", 32'(cyc), 32'(cur.req_cyc));
                chk("b_req", 32'(b_req), 32'(1));
            end
            req_len = 0;
        end
        if (a_req) req_len++;
        if (!a_req && prev_req && cur_v && cur.req_len != 0)
            chk("req_len", 32'(req_len), 32'(cur.req_len));
        if (cur_v && a_busy) begin
            chk("addr_stable", 32'(a_addr), 32'(cur.addr));
            chk("b_addr_stable", 32'(b_addr), 32'(cur.addr));
        end
        if (!a_busy && prev_busy && cur_v) begin
            chk("event_cnt", 32'(a_cnt), 32'(cur.cnt));
            chk("b_event_cnt", 32'(b_cnt), 32'(cur.cnt_b));
            chk("timeout_err", 32'(a_err), 32'(cur.err));
            chk("b_timeout_err", 32'(b_err), 32'(cur.err));
            chk("b_busy", 32'(b_busy), 32'(0));
            cur_v = 0;
        end
        prev_req  = a_req;
        prev_busy = a_busy;
    end

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (a_busy && n < 200);
        if (a_busy) chk("idle_timeout", 32'(1), 32'(0));
    endtask

    // Called at #1 after a posedge. ncyc = strobe length (1 or 2).
    task automatic send(input logic [9:0] a0, input logic [9:0] a1, input int ncyc,
                        input int exp_len, input logic exp_err, input bit ok, input bit do_wait);
        exp_t e;
        logic [9:0] fin;
        strobe = 1'b1;
        idx    = a0;
        fin    = a0;
        @(posedge clk);
        #1;
        chk("busy_rise", 32'(a_busy), 32'(1));
        if (ncyc == 2) begin
            idx = a1;
            fin = a1;
            @(posedge clk);
            #1;
        end
        strobe = 1'b0;
        idx    = ~fin;   // must not leak into the frozen address
        if (ok) begin
            exp_cnt++;
            if (exp_cnt_b < 15) exp_cnt_b++;
        end
        e.addr    = fin;
        e.req_cyc = cyc + SETUP + 1;
        e.req_len = exp_len;
        e.cnt     = exp_cnt;
        e.cnt_b   = exp_cnt_b;
        e.err     = exp_err;
        q.push_back(e);
        if (do_wait) wait_idle();
    endtask

    initial begin
        int n;
        rst_n  = 1'b0;
        strobe = 1'b0;
        idx    = '0;
        clr    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", 32'(a_req), 32'(0));
        chk("rst_addr", 32'(a_addr), 32'(0));
        chk("rst_busy", 32'(a_busy), 32'(0));
        chk("rst_err", 32'(a_err), 32'(0));
        chk("rst_cnt", 32'(a_cnt), 32'(0));
        chk("rst_cnt_b", 32'(b_cnt), 32'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single event and stale index
        ack_mode = 1;
        send(10'h1FF, 10'h000, 1, 0, 1'b0, 1, 1);
        send(10'h1FF, 10'h07A, 2, 0, 1'b0, 1, 1);

        // Encoder image: two reset codes then 256 pixels, back-to-back
        for (int i = 0; i < 258; i++)
            send((i < 2) ? 10'h1FF : 10'(i - 2), 10'h000, 1, 0, 1'b0, 1, 1);
        chk("cnt_after_image", 32'(a_cnt), 32'(260));
        chk("err_after_image", 32'(a_err), 32'(0));

        // REQ_HI timeout, then clear
        ack_mode = 0;
        repeat (4) @(posedge clk);
        #1;
        send(10'h155, 10'h000, 1, TMO, 1'b1, 0, 1);
        chk("hi_timeout_busy", 32'(a_busy), 32'(0));
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk("clr_err", 32'(a_err), 32'(0));

        // REQ_LO timeout with ACK stuck high
        ack_mode = 2;
        repeat (4) @(posedge clk);
        #1;
        send(10'h2AA, 10'h000, 1, 1, 1'b1, 0, 1);
        chk("lo_timeout_cnt", 32'(a_cnt), 32'(260));
        ack_mode = 0;
        repeat (4) @(posedge clk);
        #1;

        // Reset mid REQ_HI
        exp_cnt   = 0;
        exp_cnt_b = 0;
        send(10'h0F0, 10'h000, 1, 0, 1'b0, 0, 0);
        n = 0;
        while (!a_req && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("req_before_reset", 32'(a_req), 32'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_req", 32'(a_req), 32'(0));
        chk("midrst_busy", 32'(a_busy), 32'(0));
        chk("midrst_cnt", 32'(a_cnt), 32'(0));
        chk("midrst_err", 32'(a_err), 32'(0));
        chk("midrst_addr", 32'(a_addr), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Saturation on the 4-bit counter
        ack_mode = 1;
        for (int i = 0; i < 17; i++)
            send(10'(i * 37 + 5), 10'h000, 1, 0, 1'b0, 1, 1);
        chk("sat_cnt_a", 32'(a_cnt), 32'(17));
        chk("sat_cnt_b", 32'(b_cnt), 32'(15));

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
